imm_materializer: RTL and testbench
===================================

# imm_materializer

Inverse of the datapath's immediate sign extender: accepts a 64-bit constant plus a destination register and emits the LEGv8 MOVZ/MOVK instruction words that rebuild it. Each word carries a 16-bit immediate in bits [20:5] and a halfword shift in bits [22:21], which is the field layout the sign extender decodes in MOVZ mode. The block sits between the test/boot loader and instruction memory write port (or a trace generator), streaming words over a valid/ready handshake.

## Interface
- SKIP_ZERO, 1, 1: omit MOVK for all-zero halfwords; 0: always emit all four words (hw0..hw3).
- CLK  input  1  rising-edge clock.
- Reset_L  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_imm  input  64  constant to materialize.
- req_rd  input  5  destination register number.
- inst_valid  output  1  inst_word valid.
- inst_ready  input  1  consumer accepts inst_word.
- inst_word  output  32  encoded MOVZ/MOVK instruction.
- inst_last  output  1  inst_word is the final word of the current request.

## Operation
- States: IDLE, EMIT. req_ready = (state==IDLE). inst_valid = (state==EMIT).
- Accept on req_valid & req_ready: register imm, rd; build pending mask m[3:0], m[i] = (imm[16i+15:16i] != 0) when SKIP_ZERO=1, else 4'b1111. If m==0, force m=4'b0001. Set first=1. Go to EMIT.
- EMIT word: hw = index of lowest set bit of m; imm16 = imm[16hw+15:16hw].
- Encoding: inst_word[31:23] = first ? 9'b110100101 (MOVZ) : 9'b111100101 (MOVK); [22:21] = hw; [20:5] = imm16; [4:0] = rd.
- inst_last = (m has exactly one bit set).
- Handshake inst_valid & inst_ready: clear bit hw in m; first=0; if inst_last, go to IDLE, else stay in EMIT.
- The first emitted word is always MOVZ, even when hw != 0, because MOVZ zeroes the other halfwords.
- Word count per request: 1..4. The count equals popcount of m after the forced-zero fix.
- inst_word, inst_last, and hw are held stable while inst_valid=1 and inst_ready=0.
- Requests arriving during EMIT are not accepted. req_valid is ignored while req_ready=0, and the requester holds the request.

## Timing
- Reset (asynchronous, immediate): state=IDLE, req_ready=1, inst_valid=0, inst_last=0, inst_word=0, m=0, first=0.
- Reset asserted mid-EMIT aborts the sequence. Remaining words are discarded. After Reset_L rises, the next edge sees IDLE.
- Latency: request accepted at edge N, first word valid after edge N (visible in cycle N+1).
- Throughput: one word per cycle with inst_ready held high.
- After the last handshake at edge K, req_ready=1 in cycle K+1. A new request accepted at edge K+1 makes its first word valid in cycle K+2, leaving a one-cycle bubble between requests.
- Outputs are driven from registers/state only. No combinational path exists from inst_ready or req_valid to any output.

## Test plan
- req_imm=0x1234, req_rd=3, inst_ready=1 -> one word 0xD2824683, inst_last=1, req_ready high the following cycle.
- req_imm=0xDEAD00000000BEEF, req_rd=31 -> 0xD297DDFF, then 0xF2FBD5BF with inst_last=1. No words for hw1 or hw2.
- req_imm=0, req_rd=0 -> single word 0xD2800000, inst_last=1. With imm=0x0001000000000000, rd=0 -> single word 0xD2E00020, which is MOVZ at hw3.
- SKIP_ZERO=0, req_imm=0x1234, rd=3 -> four words 0xD2824683, 0xF2A00003, 0xF2C00003, 0xF2E00003, with inst_last only on the fourth.
- Backpressure: second request is case 2 with inst_ready low for 3 cycles on each word -> inst_word and inst_last are held constant, req_ready stays 0 throughout, and the totals are unchanged.
- Reset_L pulsed low during the second word of case 2 -> inst_valid drops immediately and req_ready=1. A subsequent case-1 request emits exactly 0xD2824683.

Source files
------------

// File: rtl/imm_materializer_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_materializer_if
// Brief    : Request and instruction-stream handshake bundle for imm_materializer
// Revision : 1.0
// ============================================================================
interface imm_materializer_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_imm;
  logic [4:0]  req_rd;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic        inst_last;

  modport master (
    output req_valid, req_imm, req_rd, inst_ready,
    input  req_ready, inst_valid, inst_word, inst_last
  );

  modport slave (
    input  req_valid, req_imm, req_rd, inst_ready,
    output req_ready, inst_valid, inst_word, inst_last
  );
endinterface
`default_nettype wire

// File: rtl/imm_materializer.sv
`default_nettype none
// ============================================================================
// Module   : imm_materializer
// Brief    : Turns a 64-bit constant into a MOVZ/MOVK word stream for LEGv8
// Revision : 1.0
// ============================================================================
module imm_materializer #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic              CLK,
  input  logic              Reset_L,
  imm_materializer_if.slave bus
);

  localparam logic [8:0] OPC_MOVZ = 9'b110100101;
  localparam logic [8:0] OPC_MOVK = 9'b111100101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] imm_q;
  logic [63:0] imm_nxt;
  logic [4:0]  rd_q;
  logic [4:0]  rd_nxt;
  logic [3:0]  mask;
  logic [3:0]  mask_nxt;
  logic        first;
  logic        first_nxt;

  logic [3:0]  nz;
  logic [3:0]  accept_mask;
  logic [1:0]  hw;
  logic [15:0] imm16;
  logic        last;
  logic        emit;

  for (genvar i = 0; i < 4; i++) begin : g_nz
    assign nz[i] = SKIP_ZERO ? (|bus.req_imm[16*i +: 16]) : 1'b1;
  end

  // A zero constant still needs one MOVZ to clear the register.
  assign accept_mask = (nz == 4'd0) ? 4'b0001 : nz;

  always_comb begin
    hw = 2'd3;
    casez (mask)
      4'b???1: hw = 2'd0;
      4'b??10: hw = 2'd1;
      4'b?100: hw = 2'd2;
      default: hw = 2'd3;
    endcase
  end

  always_comb begin
    imm16 = imm_q[15:0];
    case (hw)
      2'd0:    imm16 = imm_q[15:0];
      2'd1:    imm16 = imm_q[31:16];
      2'd2:    imm16 = imm_q[47:32];
      default: imm16 = imm_q[63:48];
    endcase
  end

  assign last = (mask != 4'd0) && ((mask & (mask - 4'd1)) == 4'd0);
  assign emit = (state == EMIT);

  assign bus.req_ready  = (state == IDLE);
  assign bus.inst_valid = emit;
  assign bus.inst_last  = emit & last;
  assign bus.inst_word  = emit ? {(first ? OPC_MOVZ : OPC_MOVK), hw, imm16, rd_q} : 32'd0;

  always_comb begin
    state_nxt = state;
    imm_nxt   = imm_q;
    rd_nxt    = rd_q;
    mask_nxt  = mask;
    first_nxt = first;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          imm_nxt   = bus.req_imm;
          rd_nxt    = bus.req_rd;
          mask_nxt  = accept_mask;
          first_nxt = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (bus.inst_ready) begin
          // Clearing the lowest set bit retires exactly halfword hw.
          mask_nxt  = mask & (mask - 4'd1);
          first_nxt = 1'b0;
          if (last) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state <= IDLE;
      imm_q <= 64'd0;
      rd_q  <= 5'd0;
      mask  <= 4'd0;
      first <= 1'b0;
    end else begin
      state <= state_nxt;
      imm_q <= imm_nxt;
      rd_q  <= rd_nxt;
      mask  <= mask_nxt;
      first <= first_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_materializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_materializer
// Brief    : Directed scoreboard bench for imm_materializer (both SKIP_ZERO modes)
// Revision : 1.0
// ============================================================================
module tb_imm_materializer;

  logic CLK = 1'b0;
  logic Reset_L;
  always #5 CLK = ~CLK;

  imm_materializer_if bus_a();
  imm_materializer_if bus_b();

  imm_materializer #(.SKIP_ZERO(1'b1)) dut_a (.CLK(CLK), .Reset_L(Reset_L), .bus(bus_a.slave));
  imm_materializer #(.SKIP_ZERO(1'b0)) dut_b (.CLK(CLK), .Reset_L(Reset_L), .bus(bus_b.slave));

  // sel chooses which instance the directed steps talk to
  logic        sel;
  logic        obs_req_ready;
  logic        obs_valid;
  logic        obs_last;
  logic [31:0] obs_word;
  assign obs_req_ready = sel ? bus_b.req_ready  : bus_a.req_ready;
  assign obs_valid     = sel ? bus_b.inst_valid : bus_a.inst_valid;
  assign obs_last      = sel ? bus_b.inst_last  : bus_a.inst_last;
  assign obs_word      = sel ? bus_b.inst_word  : bus_a.inst_word;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ready(input logic r);
    bus_a.inst_ready = r;
    bus_b.inst_ready = r;
  endtask

  // Expected stream derived directly from the MOVZ/MOVK rules.
  task automatic push_model(input logic [63:0] imm, input logic [4:0] rd, input bit skip);
    int hws[$];
    logic [15:0] h16;
    for (int h = 0; h < 4; h++) begin
      h16 = imm[16*h +: 16];
      if (!skip || h16 != 16'd0) hws.push_back(h);
    end
    if (hws.size() == 0) hws.push_back(0);
    for (int k = 0; k < hws.size(); k++) begin
      h16 = imm[16*hws[k] +: 16];
      exp_q.push_back({(k == hws.size() - 1),
                       (k == 0) ? 9'b110100101 : 9'b111100101,
                       2'(hws[k]), h16, rd});
    end
  endtask

  // Called at a negedge; presents the request for exactly one rising edge.
  task automatic send(input logic [63:0] imm, input logic [4:0] rd);
    chk("req_ready_before", {63'd0, obs_req_ready}, 64'd1);
    if (sel) begin
      bus_b.req_valid = 1'b1; bus_b.req_imm = imm; bus_b.req_rd = rd;
    end else begin
      bus_a.req_valid = 1'b1; bus_a.req_imm = imm; bus_a.req_rd = rd;
    end
    @(negedge CLK);
    bus_a.req_valid = 1'b0;
    bus_b.req_valid = 1'b0;
  endtask

  // Pops every expected word; each must be valid on consecutive cycles
  // apart from the requested stall cycles.
  task automatic drain(input int stall);
    logic [32:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (stall > 0) begin
        set_ready(1'b0);
        for (int s = 0; s < stall; s++) begin
          chk("stall_valid", {63'd0, obs_valid}, 64'd1);
          chk("stall_word", {32'd0, obs_word}, {32'd0, e[31:0]});
          chk("stall_last", {63'd0, obs_last}, {63'd0, e[32]});
          chk("stall_req_ready", {63'd0, obs_req_ready}, 64'd0);
          @(negedge CLK);
        end
      end
      set_ready(1'b1);
      chk("inst_valid", {63'd0, obs_valid}, 64'd1);
      chk("inst_word", {32'd0, obs_word}, {32'd0, e[31:0]});
      chk("inst_last", {63'd0, obs_last}, {63'd0, e[32]});
      @(negedge CLK);
    end
    chk("idle_valid", {63'd0, obs_valid}, 64'd0);
    chk("idle_req_ready", {63'd0, obs_req_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    sel = 1'b0;
    bus_a.req_valid = 1'b0; bus_a.req_imm = 64'd0; bus_a.req_rd = 5'd0;
    bus_b.req_valid = 1'b0; bus_b.req_imm = 64'd0; bus_b.req_rd = 5'd0;
    set_ready(1'b1);
    Reset_L = 1'b0;
    #1;
    chk("rst_req_ready", {63'd0, bus_a.req_ready}, 64'd1);
    chk("rst_valid", {63'd0, bus_a.inst_valid}, 64'd0);
    chk("rst_last", {63'd0, bus_a.inst_last}, 64'd0);
    chk("rst_word", {32'd0, bus_a.inst_word}, 64'd0);
    chk("rst_word_b", {32'd0, bus_b.inst_word}, 64'd0);
    repeat (2) @(negedge CLK);
    Reset_L = 1'b1;
    @(negedge CLK);

    // single halfword
    exp_q.push_back({1'b1, 32'hD2824683});
    send(64'h1234, 5'd3);
    drain(0);

    // sparse constant, back to back after the bubble
    exp_q.push_back({1'b0, 32'hD297DDFF});
    exp_q.push_back({1'b1, 32'hF2FBD5BF});
    send(64'hDEAD00000000BEEF, 5'd31);
    drain(0);

    // zero and MOVZ at hw3
    exp_q.push_back({1'b1, 32'hD2800000});
    send(64'd0, 5'd0);
    drain(0);
    exp_q.push_back({1'b1, 32'hD2E00020});
    send(64'h0001000000000000, 5'd0);
    drain(0);

    // backpressure: case 1 then case 2 with 3 stall cycles per word
    exp_q.push_back({1'b1, 32'hD2824683});
    send(64'h1234, 5'd3);
    drain(0);
    exp_q.push_back({1'b0, 32'hD297DDFF});
    exp_q.push_back({1'b1, 32'hF2FBD5BF});
    send(64'hDEAD00000000BEEF, 5'd31);
    drain(3);

    // random constants with zeroed halfwords
    for (int n = 0; n < 4; n++) begin
      r = {$urandom, $urandom};
      for (int h = 0; h < 4; h++) if ($urandom_range(1, 0) == 0) r[16*h +: 16] = 16'd0;
      push_model(r, 5'($urandom_range(31, 0)), 1'b1);
      send(r, exp_q[0][4:0]);
      drain(n % 2);
    end

    // always-four-words instance
    sel = 1'b1;
    exp_q.push_back({1'b0, 32'hD2824683});
    exp_q.push_back({1'b0, 32'hF2A00003});
    exp_q.push_back({1'b0, 32'hF2C00003});
    exp_q.push_back({1'b1, 32'hF2E00003});
    send(64'h1234, 5'd3);
    drain(0);
    r = {$urandom, $urandom};
    push_model(r, 5'd17, 1'b0);
    send(r, 5'd17);
    drain(1);
    sel = 1'b0;

    // reset in the middle of the second word
    send(64'hDEAD00000000BEEF, 5'd31);
    chk("pre_rst_word0", {32'd0, obs_word}, 64'hD297DDFF);
    @(negedge CLK);
    chk("pre_rst_word1", {32'd0, obs_word}, 64'hF2FBD5BF);
    Reset_L = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, obs_valid}, 64'd0);
    chk("mid_rst_req_ready", {63'd0, obs_req_ready}, 64'd1);
    chk("mid_rst_word", {32'd0, obs_word}, 64'd0);
    @(negedge CLK);
    Reset_L = 1'b1;
    @(negedge CLK);
    exp_q.push_back({1'b1, 32'hD2824683});
    send(64'h1234, 5'd3);
    drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
